id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Registers decoded operands and applies EX/MEM and MEM/WB forwarding.
- Presents ALUOp, SrcDataA and SrcDataB to the ALU with a valid/ready handshake.
- A 2-entry buffer (output slot plus skid slot) keeps InReady a pure register output; held entries snoop writebacks so their operands never go stale.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous squash of all held entries.
- InValid  in  1  decode stage presents an instruction.
- InReady  out  1  stage can accept; registered.
- ALUOpIn  in  3  ALU operation code.
- ALUSrcB  in  1  0: B = Rt operand; 1: B = Imm.
- RsAddr  in  AW  source A register number.
- RtAddr  in  AW  source B register number.
- RsData  in  DW  register-file read A.
- RtData  in  DW  register-file read B.
- Imm  in  DW  extended immediate.
- RdAddrIn  in  AW  destination register number.
- RegWriteIn  in  1  instruction writes a register.
- ExMemRegWrite  in  1  EX/MEM write enable.
- ExMemRd  in  AW  EX/MEM destination register.
- ExMemResult  in  DW  EX/MEM value.
- MemWbRegWrite  in  1  MEM/WB write enable.
- MemWbRd  in  AW  MEM/WB destination register.
- MemWbData  in  DW  MEM/WB value.
- OutValid  out  1  output slot holds an instruction.
- OutReady  in  1  EX stage consumes the output slot.
- ALUOp  out  3  to ALU.
- SrcDataA  out  DW  to ALU.
- SrcDataB  out  DW  to ALU (Rt operand or Imm).
- StoreData  out  DW  forwarded Rt operand, regardless of ALUSrcB.
- RdAddr  out  AW  destination register.
- RegWrite  out  1  qualified by OutValid; 0 when OutValid=0.

Behaviour:
- Reset: state EMPTY; OutValid=0, InReady=1, RegWrite=0, all data outputs 0, skid slot cleared.
- States:
  - EMPTY (no entries).
  - ONE (output slot valid).
  - FULL (output + skid valid).
- InReady = (state != FULL).
- accept = InValid && InReady.
- pop = OutValid && OutReady.
- Transitions:
  - EMPTY: accept -> ONE (entry into output slot).
  - ONE:
    - accept && pop -> ONE (new entry replaces output).
    - accept && !pop -> FULL (new entry into skid).
    - !accept && pop -> EMPTY.
  - FULL:
    - pop -> ONE (skid moves to output).
    - otherwise hold.
    - No accept is possible in FULL.
- Latency: an instruction accepted at edge N is on the outputs after edge N (1 cycle) when the stage was EMPTY, or ONE with a simultaneous pop.
- Forwarding at capture, per source (Rs, and Rt when used):
  - If ExMemRegWrite && ExMemRd==src && src!=0, use ExMemResult.
  - Else if MemWbRegWrite && MemWbRd==src && src!=0, use MemWbData.
  - Else use the register-file value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 always yields the register-file value (0).
- Snoop: every cycle, each held entry re-applies the same forwarding rule to its stored Rs and Rt operands using the current ExMem/MemWb inputs, with the same priority. The Imm path is never snooped. The snooped value is visible the cycle after the edge.
- Entries store RsAddr, RtAddr, ALUSrcB and Imm for snooping.
- SrcDataB = ALUSrcB ? Imm : forwarded Rt. StoreData is always the forwarded Rt.
- Flush:
  - Next edge -> EMPTY, OutValid=0, InReady=1.
  - Wins over accept: an instruction offered during flush is dropped.
  - Wins over pop: a pop in the same cycle is still counted as consumed by EX.
- Reset mid-operation: immediate return to the reset state; in-flight entries are discarded.
- Data outputs keep their last value when OutValid=0; only RegWrite is forced to 0.

Optional Feature:
- Macro: ID_EX_SNOOP_EN.
- Defined: held-entry snooping as above.
- Undefined:
  - Operands are fixed at capture.
  - Address and Imm storage for snooping is removed.
  - The upstream hazard unit must stall any dependent instruction while it is held.
  - Capture-time forwarding remains in both builds.

Test Plan:
- Reset then idle -> OutValid=0, InReady=1, RegWrite=0, SrcDataA=0.
- Accept ALUOpIn=000, RsData=5, RtData=7, ALUSrcB=0, OutReady=1 -> next cycle SrcDataA=5, SrcDataB=7, OutValid=1; the next cycle with no input gives OutValid=0.
- Capture with RsAddr=3, ExMemRd=3/ExMemResult=0x11 and MemWbRd=3/MemWbData=0x22 both writing -> SrcDataA=0x11. Same with RsAddr=0 -> SrcDataA=RsData.
- OutReady=0, accept two instructions A then B -> state FULL, InReady=0, outputs A. Raise OutReady -> B appears next cycle, InReady=1.
- (ID_EX_SNOOP_EN) Hold an entry with RtAddr=4, ALUSrcB=0, OutReady=0. Pulse MemWbRegWrite with MemWbRd=4, MemWbData=0xABCD -> SrcDataB=StoreData=0xABCD next cycle. With ALUSrcB=1, SrcDataB stays Imm.
- In FULL, assert Flush with InValid=1 -> next cycle OutValid=0, InReady=1, RegWrite=0, and the offered instruction never appears.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers decoded operands with EX/MEM and MEM/WB forwarding
// behind a 2-entry (output + skid) buffer. Define ID_EX_SNOOP_EN to refresh held operands.
module id_ex_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          Flush,
   input  logic          InValid,
   output logic          InReady,
   input  logic [2:0]    ALUOpIn,
   input  logic          ALUSrcB,
   input  logic [AW-1:0] RsAddr,
   input  logic [AW-1:0] RtAddr,
   input  logic [DW-1:0] RsData,
   input  logic [DW-1:0] RtData,
   input  logic [DW-1:0] Imm,
   input  logic [AW-1:0] RdAddrIn,
   input  logic          RegWriteIn,
   input  logic          ExMemRegWrite,
   input  logic [AW-1:0] ExMemRd,
   input  logic [DW-1:0] ExMemResult,
   input  logic          MemWbRegWrite,
   input  logic [AW-1:0] MemWbRd,
   input  logic [DW-1:0] MemWbData,
   output logic          OutValid,
   input  logic          OutReady,
   output logic [2:0]    ALUOp,
   output logic [DW-1:0] SrcDataA,
   output logic [DW-1:0] SrcDataB,
   output logic [DW-1:0] StoreData,
   output logic [AW-1:0] RdAddr,
   output logic          RegWrite
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   typedef struct packed {
      logic [2:0]    op;
      logic [AW-1:0] rd;
      logic          wr;
      logic [DW-1:0] a;
      logic [DW-1:0] rt;
`ifdef ID_EX_SNOOP_EN
      logic          srcb;
      logic [AW-1:0] rs_addr;
      logic [AW-1:0] rt_addr;
      logic [DW-1:0] imm;
`else
      logic [DW-1:0] b;
`endif
   } entry_t;

   logic [1:0] state, state_nxt;
   logic       in_ready_q;
   entry_t     out_q, skid_q, out_nxt, skid_nxt, cap;
   logic       accept, pop;

   // EX/MEM beats MEM/WB; register 0 is never forwarded
   function automatic logic [DW-1:0] fwd(input logic [AW-1:0] src, input logic [DW-1:0] val);
      if (ExMemRegWrite && ExMemRd == src && src != '0)
         return ExMemResult;
      else if (MemWbRegWrite && MemWbRd == src && src != '0)
         return MemWbData;
      else
         return val;
   endfunction

   function automatic entry_t snoop(input entry_t e);
      entry_t r;
      r = e;
`ifdef ID_EX_SNOOP_EN
      r.a  = fwd(e.rs_addr, e.a);
      r.rt = fwd(e.rt_addr, e.rt);
`endif
      return r;
   endfunction

   always_comb begin
      accept    = InValid && in_ready_q;
      pop       = (state != EMPTY) && OutReady;
      cap       = '0;
      cap.op    = ALUOpIn;
      cap.rd    = RdAddrIn;
      cap.wr    = RegWriteIn;
      cap.a     = fwd(RsAddr, RsData);
      cap.rt    = fwd(RtAddr, RtData);
`ifdef ID_EX_SNOOP_EN
      cap.srcb    = ALUSrcB;
      cap.rs_addr = RsAddr;
      cap.rt_addr = RtAddr;
      cap.imm     = Imm;
`else
      cap.b = ALUSrcB ? Imm : cap.rt;
`endif
      state_nxt = state;
      out_nxt   = out_q;
      skid_nxt  = skid_q;
      case (state)
         EMPTY: begin
            if (accept) begin
               out_nxt   = cap;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (accept && pop) begin
               out_nxt = cap;
            end else if (accept) begin
               out_nxt   = snoop(out_q);
               skid_nxt  = cap;
               state_nxt = FULL;
            end else if (pop) begin
               state_nxt = EMPTY;
            end else begin
               out_nxt = snoop(out_q);
            end
         end
         FULL: begin
            if (pop) begin
               out_nxt   = snoop(skid_q);
               state_nxt = ONE;
            end else begin
               out_nxt  = snoop(out_q);
               skid_nxt = snoop(skid_q);
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // flushed entries are dropped but the visible data holds its last value
      if (Flush) begin
         state_nxt = EMPTY;
         out_nxt   = out_q;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != FULL);
         out_q      <= out_nxt;
         skid_q     <= skid_nxt;
      end
   end

   assign InReady   = in_ready_q;
   assign OutValid  = (state != EMPTY);
   assign ALUOp     = out_q.op;
   assign SrcDataA  = out_q.a;
`ifdef ID_EX_SNOOP_EN
   assign SrcDataB  = out_q.srcb ? out_q.imm : out_q.rt;
`else
   assign SrcDataB  = out_q.b;
`endif
   assign StoreData = out_q.rt;
   assign RdAddr    = out_q.rd;
   assign RegWrite  = OutValid && out_q.wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected entries are queued on accept and
// compared while they sit in the output slot.
module tb_id_ex_stage;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          CLK, Reset, Flush, InValid, InReady;
   logic [2:0]    ALUOpIn;
   logic          ALUSrcB;
   logic [AW-1:0] RsAddr, RtAddr, RdAddrIn;
   logic [DW-1:0] RsData, RtData, Imm;
   logic          RegWriteIn;
   logic          ExMemRegWrite, MemWbRegWrite;
   logic [AW-1:0] ExMemRd, MemWbRd;
   logic [DW-1:0] ExMemResult, MemWbData;
   logic          OutValid, OutReady;
   logic [2:0]    ALUOp;
   logic [DW-1:0] SrcDataA, SrcDataB, StoreData;
   logic [AW-1:0] RdAddr;
   logic          RegWrite;

   id_ex_stage #(.DW(DW), .AW(AW)) dut (
      .CLK(CLK), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
      .ALUOpIn(ALUOpIn), .ALUSrcB(ALUSrcB), .RsAddr(RsAddr), .RtAddr(RtAddr),
      .RsData(RsData), .RtData(RtData), .Imm(Imm), .RdAddrIn(RdAddrIn),
      .RegWriteIn(RegWriteIn), .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd),
      .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd),
      .MemWbData(MemWbData), .OutValid(OutValid), .OutReady(OutReady), .ALUOp(ALUOp),
      .SrcDataA(SrcDataA), .SrcDataB(SrcDataB), .StoreData(StoreData),
      .RdAddr(RdAddr), .RegWrite(RegWrite)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [AW-1:0] rs, rt, rd;
      logic          srcb, wr;
      logic [2:0]    op;
      logic [DW-1:0] a, rtv, imm;
   } ent_t;

   ent_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] src, input logic [DW-1:0] val);
      if (src == '0) return val;
      if (ExMemRegWrite && ExMemRd == src) return ExMemResult;
      if (MemWbRegWrite && MemWbRd == src) return MemWbData;
      return val;
   endfunction

   // called at posedge+1 with inputs set; checks at the falling edge, then advances
   task automatic tick();
      logic pop, acc;
      ent_t e;
      #4;
      check("outvalid", DW'(OutValid), DW'(q.size() > 0));
      check("inready", DW'(InReady), DW'(q.size() < 2));
      if (q.size() > 0) begin
         check("srca", SrcDataA, q[0].a);
         check("srcb", SrcDataB, q[0].srcb ? q[0].imm : q[0].rtv);
         check("store", StoreData, q[0].rtv);
         check("aluop", DW'(ALUOp), DW'(q[0].op));
         check("rd", DW'(RdAddr), DW'(q[0].rd));
         check("regwrite", DW'(RegWrite), DW'(q[0].wr));
      end else begin
         check("regwrite_idle", DW'(RegWrite), '0);
      end
      pop = (q.size() > 0) && OutReady;
      acc = InValid && (q.size() < 2) && !Flush;
      e.rs = RsAddr; e.rt = RtAddr; e.rd = RdAddrIn; e.srcb = ALUSrcB; e.wr = RegWriteIn;
      e.op = ALUOpIn; e.imm = Imm;
      e.a = model_fwd(RsAddr, RsData);
      e.rtv = model_fwd(RtAddr, RtData);
      if (pop) q.delete(0);
`ifdef ID_EX_SNOOP_EN
      foreach (q[i]) begin
         q[i].a   = model_fwd(q[i].rs, q[i].a);
         q[i].rtv = model_fwd(q[i].rt, q[i].rtv);
      end
`endif
      if (Flush) q.delete();
      else if (acc) q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      InValid = 1'b0; Flush = 1'b0; ExMemRegWrite = 1'b0; MemWbRegWrite = 1'b0;
   endtask

   task automatic offer(input logic [2:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic srcb,
                        input logic [DW-1:0] imm, input logic [AW-1:0] rd, input logic wr);
      InValid = 1'b1; ALUOpIn = op; RsAddr = rs; RtAddr = rt; RsData = rsd; RtData = rtd;
      ALUSrcB = srcb; Imm = imm; RdAddrIn = rd; RegWriteIn = wr;
   endtask

   initial begin
      Reset = 1'b1; idle(); OutReady = 1'b0;
      ALUOpIn = '0; ALUSrcB = 1'b0; RsAddr = '0; RtAddr = '0; RsData = '0; RtData = '0;
      Imm = '0; RdAddrIn = '0; RegWriteIn = 1'b0; ExMemRd = '0; ExMemResult = '0;
      MemWbRd = '0; MemWbData = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_srca", SrcDataA, '0);
      check("rst_srcb", SrcDataB, '0);
      check("rst_outvalid", DW'(OutValid), '0);
      check("rst_inready", DW'(InReady), DW'(1));
      Reset = 1'b0;
      tick(); tick();

      // basic pass-through, then idle
      OutReady = 1'b1;
      offer(3'b000, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 32'h0, 5'd9, 1'b1);
      tick();
      idle(); tick(); tick();

      // capture forwarding priority and register 0
      ExMemRegWrite = 1'b1; ExMemRd = 5'd3; ExMemResult = 32'h11;
      MemWbRegWrite = 1'b1; MemWbRd = 5'd3; MemWbData = 32'h22;
      offer(3'b010, 5'd3, 5'd3, 32'h99, 32'h98, 1'b0, 32'h0, 5'd4, 1'b1);
      tick();
      InValid = 1'b0; tick();
      check("fwd_exmem", SrcDataA, 32'h11);
      ExMemRegWrite = 1'b1; ExMemRd = 5'd0; MemWbRegWrite = 1'b1; MemWbRd = 5'd0;
      offer(3'b011, 5'd0, 5'd3, 32'h77, 32'h66, 1'b0, 32'h0, 5'd5, 1'b0);
      ExMemRd = 5'd8; MemWbRd = 5'd3;
      tick();
      InValid = 1'b0; tick();
      check("fwd_r0", SrcDataA, 32'h77);
      check("fwd_memwb_rt", StoreData, 32'h22);
      idle(); tick();

      // skid: fill with OutReady low, then drain
      OutReady = 1'b0;
      offer(3'b001, 5'd6, 5'd7, 32'hA, 32'hB, 1'b0, 32'h0, 5'd1, 1'b1); tick();
      offer(3'b100, 5'd6, 5'd7, 32'hC, 32'hD, 1'b1, 32'h1234, 5'd2, 1'b1); tick();
      idle(); tick();
      check("full_inready", DW'(InReady), '0);
      OutReady = 1'b1; tick(); tick(); tick();

`ifdef ID_EX_SNOOP_EN
      OutReady = 1'b0;
      offer(3'b101, 5'd2, 5'd4, 32'h1, 32'h2, 1'b0, 32'h55, 5'd3, 1'b1); tick();
      idle(); MemWbRegWrite = 1'b1; MemWbRd = 5'd4; MemWbData = 32'hABCD; tick();
      idle(); tick();
      check("snoop_srcb", SrcDataB, 32'hABCD);
      check("snoop_store", StoreData, 32'hABCD);
      OutReady = 1'b1; tick();
      OutReady = 1'b0;
      offer(3'b101, 5'd2, 5'd4, 32'h1, 32'h2, 1'b1, 32'h55, 5'd3, 1'b1); tick();
      idle(); MemWbRegWrite = 1'b1; MemWbRd = 5'd4; MemWbData = 32'hBEEF; tick();
      idle(); tick();
      check("snoop_imm", SrcDataB, 32'h55);
      check("snoop_store_imm", StoreData, 32'hBEEF);
      OutReady = 1'b1; tick();
`endif

      // flush in FULL with an instruction offered
      OutReady = 1'b0;
      offer(3'b001, 5'd1, 5'd1, 32'h1, 32'h1, 1'b0, 32'h0, 5'd1, 1'b1); tick();
      offer(3'b010, 5'd1, 5'd1, 32'h2, 32'h2, 1'b0, 32'h0, 5'd2, 1'b1); tick();
      offer(3'b011, 5'd1, 5'd1, 32'h3, 32'h3, 1'b0, 32'h0, 5'd3, 1'b1); Flush = 1'b1; tick();
      idle(); OutReady = 1'b1; tick(); tick();

      // asynchronous reset mid-operation
      OutReady = 1'b0;
      offer(3'b110, 5'd1, 5'd2, 32'h44, 32'h45, 1'b0, 32'h0, 5'd7, 1'b1); tick();
      idle(); Reset = 1'b1; #1;
      check("midrst_outvalid", DW'(OutValid), '0);
      check("midrst_inready", DW'(InReady), DW'(1));
      check("midrst_regwrite", DW'(RegWrite), '0);
      check("midrst_srca", SrcDataA, '0);
      q.delete();
      #2 Reset = 1'b0;
      @(posedge CLK); #1;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         offer(3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         InValid       = 1'($urandom_range(0, 2) != 0);
         OutReady      = 1'($urandom_range(0, 2) == 0);
         Flush         = ($urandom_range(0, 15) == 0);
         ExMemRegWrite = 1'($urandom_range(0, 1));
         ExMemRd       = 5'($urandom_range(0, 3));
         ExMemResult   = $urandom;
         MemWbRegWrite = 1'($urandom_range(0, 1));
         MemWbRd       = 5'($urandom_range(0, 3));
         MemWbData     = $urandom;
         tick();
      end
      idle(); OutReady = 1'b1; tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
